// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-word handshake between uart_rx_cfg and its consumer
// master = receiver side (drives word, flags, busy); slave = consumer side (drives ready)
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx_ready;
  logic                 o_rx_valid;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    input  i_rx_ready,
    output o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_break, o_overrun, o_busy
  );

  modport slave (
    output i_rx_ready,
    input  o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_break, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable-format UART receiver with majority sampling and held output word
// Frame: start, DATA_BITS data LSB first, optional parity, 1 or 2 stop bits; decisions on synchronised line.
module uart_rx_cfg #(
  parameter int TICKS_PER_BIT = 128,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx_serial,
  uart_rx_cfg_if.master rx
);

  localparam int CW  = $clog2(TICKS_PER_BIT);
  localparam int MID = (TICKS_PER_BIT - 1) / 2;
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_HI   = CW'(MID + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_WAIT_HI
  } state_t;

  state_t               state, state_d;
  logic                 rx_meta, rx_sync;
  logic [CW-1:0]        cnt;
  logic                 samp_lo, samp_mid;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_idx;
  logic                 stop_bad;
  logic                 stop_high;

  logic maj, maj_pt, wrap, last_stop;
  logic par_calc, par_err, brk;

  assign maj_pt    = (cnt == CNT_HI);
  assign wrap      = (cnt == CNT_LAST);
  assign maj       = (samp_lo & samp_mid) | (samp_lo & rx_sync) | (samp_mid & rx_sync);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

  assign par_calc = (^shreg) ^ par_bit;
  assign par_err  = (PARITY == 1) ? ~par_calc : (PARITY == 2) ? par_calc : 1'b0;
  // Break needs every sampled bit low, including parity and all stop bits.
  assign brk      = (shreg == '0) & ~par_bit & ~stop_high;

  assign rx.o_busy = (state != S_IDLE);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (!rx_sync) state_d = S_START;
      S_START: begin
        if (maj_pt && maj) state_d = S_IDLE;
        else if (wrap)     state_d = S_DATA;
      end
      S_DATA: begin
        if (wrap && (bit_idx == BIT_LAST))
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY:  if (wrap) state_d = S_STOP;
      // Leave at the last stop majority point so a following start edge is not missed.
      S_STOP:    if (maj_pt && last_stop) state_d = S_DONE;
      S_DONE:    state_d = stop_bad ? S_WAIT_HI : S_IDLE;
      S_WAIT_HI: if (rx_sync) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      cnt       <= '0;
      samp_lo   <= 1'b1;
      samp_mid  <= 1'b1;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop_idx  <= 1'b0;
      stop_bad  <= 1'b0;
      stop_high <= 1'b0;
    end else begin
      rx_meta <= i_rx_serial;
      rx_sync <= rx_meta;

      if (state == S_IDLE || wrap) cnt <= '0;
      else                         cnt <= cnt + 1'b1;

      if (cnt == CNT_LO)  samp_lo  <= rx_sync;
      if (cnt == CNT_MID) samp_mid <= rx_sync;

      case (state)
        S_IDLE: begin
          bit_idx   <= '0;
          par_bit   <= 1'b0;
          stop_idx  <= 1'b0;
          stop_bad  <= 1'b0;
          stop_high <= 1'b0;
        end
        S_DATA: begin
          if (maj_pt) shreg[bit_idx] <= maj;
          if (wrap)   bit_idx <= bit_idx + 1'b1;
        end
        S_PARITY: begin
          if (maj_pt) par_bit <= maj;
        end
        S_STOP: begin
          if (maj_pt) begin
            if (maj) stop_high <= 1'b1;
            else     stop_bad  <= 1'b1;
          end
          if (wrap) stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output word register: a new word in DONE wins over a same-cycle accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx.o_rx_valid   <= 1'b0;
      rx.o_rx_data    <= '0;
      rx.o_parity_err <= 1'b0;
      rx.o_frame_err  <= 1'b0;
      rx.o_break      <= 1'b0;
      rx.o_overrun    <= 1'b0;
    end else if (state == S_DONE) begin
      rx.o_rx_valid   <= 1'b1;
      rx.o_rx_data    <= shreg;
      rx.o_parity_err <= par_err;
      rx.o_frame_err  <= stop_bad;
      rx.o_break      <= brk;
      rx.o_overrun    <= rx.o_rx_valid & ~rx.i_rx_ready;
    end else if (rx.o_rx_valid && rx.i_rx_ready) begin
      rx.o_rx_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed frames against uart_rx_cfg (16 ticks/bit, 8E1)
module tb_uart_rx_cfg;
  localparam int TPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int words = 0;
  int valid_cyc = 0;
  logic [7:0] last_data = '0;
  logic last_par = 1'b0, last_frm = 1'b0, last_brk = 1'b0, last_ovr = 1'b0;
  int w0, v0;

  uart_rx_cfg_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_cfg #(
    .TICKS_PER_BIT(TPB),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_serial(line),
    .rx(rx_if)
  );

  always #5 clk = ~clk;

  // Records every accepted word, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.o_rx_valid) valid_cyc++;
      if (rx_if.o_rx_valid && rx_if.i_rx_ready) begin
        words++;
        last_data = rx_if.o_rx_data;
        last_par  = rx_if.o_parity_err;
        last_frm  = rx_if.o_frame_err;
        last_brk  = rx_if.o_break;
        last_ovr  = rx_if.o_overrun;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic v);
    line = v;
    tick(TPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    line = 1'b1;
    tick(2 * TPB);
  endtask

  function automatic logic [6:0] out_vec();
    return {rx_if.o_rx_valid, rx_if.o_parity_err, rx_if.o_frame_err, rx_if.o_break,
            rx_if.o_overrun, rx_if.o_busy, |rx_if.o_rx_data};
  endfunction

  initial begin
    rx_if.i_rx_ready = 1'b1;
    tick(3);
    check_eq("reset_outputs", {25'd0, out_vec()}, 32'h0);
    rst_n = 1'b1;
    tick(4);

    // Clean word, single-cycle valid
    w0 = words; v0 = valid_cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("t1_words", words - w0, 1);
    check_eq("t1_valid_cycles", valid_cyc - v0, 1);
    check_eq("t1_data", last_data, 8'hA5);
    check_eq("t1_flags", {last_par, last_frm, last_brk, last_ovr}, 4'b0000);

    // Wrong parity bit
    w0 = words;
    send_frame(8'h3C, 1'b1, 1'b1);
    check_eq("t2_words", words - w0, 1);
    check_eq("t2_data", last_data, 8'h3C);
    check_eq("t2_parity_err", last_par, 1'b1);
    check_eq("t2_frame_err", last_frm, 1'b0);

    // Framing error then a clean frame
    w0 = words;
    send_frame(8'h81, 1'b0, 1'b0);
    check_eq("t3_words", words - w0, 1);
    check_eq("t3_data", last_data, 8'h81);
    check_eq("t3_frame_err", last_frm, 1'b1);
    check_eq("t3_break", last_brk, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    check_eq("t3_next_words", words - w0, 2);
    check_eq("t3_next_data", last_data, 8'h55);
    check_eq("t3_next_flags", {last_par, last_frm, last_brk}, 3'b000);

    // Held break
    w0 = words;
    line = 1'b0;
    tick(12 * TPB);
    check_eq("t4_words_low", words - w0, 1);
    check_eq("t4_data", last_data, 8'h00);
    check_eq("t4_break", last_brk, 1'b1);
    check_eq("t4_frame_err", last_frm, 1'b1);
    check_eq("t4_busy_low", rx_if.o_busy, 1'b1);
    line = 1'b1;
    tick(2 * TPB);
    check_eq("t4_words_high", words - w0, 1);
    check_eq("t4_busy_high", rx_if.o_busy, 1'b0);

    // Short glitch rejected
    w0 = words; v0 = valid_cyc;
    line = 1'b0;
    tick(4);
    line = 1'b1;
    check_eq("t5_busy_start", rx_if.o_busy, 1'b1);
    tick(16);
    check_eq("t5_busy_end", rx_if.o_busy, 1'b0);
    check_eq("t5_no_valid", valid_cyc - v0, 0);

    // Overrun with ready low
    w0 = words;
    rx_if.i_rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    check_eq("t6_valid1", rx_if.o_rx_valid, 1'b1);
    check_eq("t6_data1", rx_if.o_rx_data, 8'h11);
    check_eq("t6_ovr1", rx_if.o_overrun, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    check_eq("t6_valid2", rx_if.o_rx_valid, 1'b1);
    check_eq("t6_data2", rx_if.o_rx_data, 8'h22);
    check_eq("t6_ovr2", rx_if.o_overrun, 1'b1);
    rx_if.i_rx_ready = 1'b1;
    tick(1);
    rx_if.i_rx_ready = 1'b0;
    check_eq("t6_valid_drop", rx_if.o_rx_valid, 1'b0);
    check_eq("t6_words", words - w0, 1);
    check_eq("t6_acc_data", last_data, 8'h22);
    rx_if.i_rx_ready = 1'b1;

    // Reset mid-DATA
    w0 = words;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check_eq("t7_busy_mid", rx_if.o_busy, 1'b1);
    line = 1'b1;
    rst_n = 1'b0;
    tick(2);
    check_eq("t7_reset_outputs", {25'd0, out_vec()}, 32'h0);
    rst_n = 1'b1;
    tick(3 * TPB);
    check_eq("t7_no_word", words - w0, 0);
    check_eq("t7_idle", rx_if.o_busy, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_eq("t7_resume_words", words - w0, 1);
    check_eq("t7_resume_data", last_data, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
